// File: rtl/noc_input_port_buffer.sv
// Wormhole input-port flit buffer: FIFO, head-flit route decode, locked route, credit return.
// Optional starvation monitor enabled by defining NOC_IBUF_STARVE_MON_EN.
module noc_input_port_buffer #(
  parameter int P            = 4,
  parameter int DEPTH        = 4,
  parameter int DATA_W       = 32,
  parameter int DST_W        = 2,
  parameter int STARVE_LIMIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W+1:0] flit_in_i,
  input  logic              flit_in_wr_i,
  output logic              credit_o,
  output logic [P-1:0]      req_o,
  input  logic [P-1:0]      gnt_i,
  output logic [DATA_W+1:0] flit_out_o,
  output logic              flit_out_vld_o,
  output logic              lock_o,
  output logic              overflow_err_o,
  output logic              proto_err_o,
  output logic              starve_o
);

  localparam int FW = DATA_W + 2;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  localparam logic [1:0] T_BODY   = 2'b00;
  localparam logic [1:0] T_TAIL   = 2'b01;
  localparam logic [1:0] T_HEAD   = 2'b10;
  localparam logic [1:0] T_SINGLE = 2'b11;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

  logic [FW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [P-1:0]  r_port;
  logic [P-1:0]  w_port_nxt;
  logic          r_credit;
  logic          r_ovf;
  logic          r_proto;

  logic          w_empty;
  logic          w_full;
  logic [FW-1:0] w_head;
  logic [1:0]    w_type;
  logic [31:0]   w_dst_ext;
  logic          w_dst_ok;
  logic [P-1:0]  w_dec;
  logic [P-1:0]  w_req;
  logic          w_drop;
  logic          w_xfer;
  logic          w_deq;
  logic          w_wr_en;

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_head    = r_mem[r_rd_ptr[AW-1:0]];
  assign w_type    = w_head[FW-1:FW-2];
  assign w_dst_ext = 32'(w_head[DST_W-1:0]);
  assign w_dst_ok  = (w_dst_ext < 32'(P));

  // One-hot decode of the head flit destination
  always_comb begin
    w_dec = '0;
    for (int i = 0; i < P; i++) begin
      w_dec[i] = (w_dst_ext == 32'(i));
    end
  end

  // Request and drop decisions for the flit currently at the FIFO head
  always_comb begin
    w_req  = '0;
    w_drop = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_empty) begin
          w_req = '0;
        end else if ((w_type == T_HEAD) || (w_type == T_SINGLE)) begin
          if (w_dst_ok) begin
            w_req = w_dec;
          end else begin
            w_drop = 1'b1;
          end
        end else begin
          w_drop = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (w_empty) begin
          w_req = '0;
        end else begin
          w_req = r_port;
        end
      end
      default: begin
        w_req  = '0;
        w_drop = 1'b0;
      end
    endcase
  end

  assign w_xfer  = |(w_req & gnt_i);
  assign w_deq   = w_xfer | w_drop;
  assign w_wr_en = flit_in_wr_i && (!w_full || w_deq);

  // Route lock: a granted HEAD opens the worm, a granted TAIL closes it
  always_comb begin
    w_state_nxt = r_state;
    w_port_nxt  = r_port;
    case (r_state)
      S_IDLE: begin
        if (w_xfer && (w_type == T_HEAD)) begin
          w_state_nxt = S_ACTIVE;
          w_port_nxt  = w_req;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ACTIVE: begin
        if (w_xfer && (w_type == T_TAIL)) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_ACTIVE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM state and latched output port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_port  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_port  <= w_port_nxt;
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[AW-1:0]] <= flit_in_i;
    end
  end

  // FIFO pointers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

  // Credit return and sticky error flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_credit <= 1'b0;
      r_ovf    <= 1'b0;
      r_proto  <= 1'b0;
    end else begin
      r_credit <= w_deq;
      if (flit_in_wr_i && w_full && !w_deq) begin
        r_ovf <= 1'b1;
      end
      if (w_drop) begin
        r_proto <= 1'b1;
      end
    end
  end

`ifdef NOC_IBUF_STARVE_MON_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [SW-1:0] CNT_ONE    = SW'(1);

  logic [SW-1:0] r_starve_cnt;

  // Saturating count of consecutive cycles spent requesting without a transfer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (w_xfer || (w_req == '0)) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt != STARVE_MAX) begin
      r_starve_cnt <= r_starve_cnt + CNT_ONE;
    end else begin
      r_starve_cnt <= r_starve_cnt;
    end
  end

  assign starve_o = (r_starve_cnt == STARVE_MAX);
`else
  assign starve_o = 1'b0;
`endif

  assign req_o          = w_req;
  assign flit_out_o     = w_head;
  assign flit_out_vld_o = w_xfer;
  assign lock_o         = (r_state == S_ACTIVE);
  assign credit_o       = r_credit;
  assign overflow_err_o = r_ovf;
  assign proto_err_o    = r_proto;

endmodule
